spi_adxl362_responder: RTL and testbench

- Synthesizable SPI subordinate that emulates the ADXL362 register protocol: the far end of our adxl362_controller.
- Used as a loopback target on the board and as the DUT partner in controller regressions.
- Holds a byte register file, serves reads and writes, supports burst auto-increment, and exposes live X/Y/Z sample inputs as read-only registers.

---
 rtl/spi_adxl362_responder_if.sv | 11 +
 rtl/spi_adxl362_responder.sv | 188 ++++++++++++++++++
 tb/tb_spi_adxl362_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_adxl362_responder_if.sv
// SPI bus between an ADXL362-style initiator and the responder.
// The initiator drives SCLK/CS/MOSI; the responder drives MISO.
interface spi_adxl362_responder_if;
  logic SPI_SCLK;
  logic SPI_CS;
  logic SPI_MOSI;
  logic SPI_MISO;

  modport master (output SPI_SCLK, output SPI_CS, output SPI_MOSI, input SPI_MISO);
  modport slave  (input SPI_SCLK, input SPI_CS, input SPI_MOSI, output SPI_MISO);
endinterface

// File: rtl/spi_adxl362_responder.sv
// SPI mode-0 subordinate emulating the ADXL362 register protocol:
// byte register file, burst read/write with auto-increment, live X/Y/Z sample registers.
module spi_adxl362_responder #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned REG_COUNT     = 64,
  parameter logic [7:0]  RO_LIMIT      = 8'h20,
  parameter logic [7:0]  DEVID_AD      = 8'hAD,
  parameter logic [7:0]  PARTID        = 8'hF2
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_adxl362_responder_if.slave spi,
  input  logic [7:0]             sample_x,
  input  logic [7:0]             sample_y,
  input  logic [7:0]             sample_z,
  output logic                   reg_wr_valid,
  output logic [7:0]             reg_wr_addr,
  output logic [7:0]             reg_wr_data,
  output logic                   active
);

  localparam int AW = $clog2(REG_COUNT);
  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  if (REG_COUNT > 256 || REG_COUNT < 16 || CLK_FREQUENCY < 8) begin : g_param_check
    $error("spi_adxl362_responder: unsupported REG_COUNT or CLK_FREQUENCY");
  end

  // Per-address readable / writable maps, folded at elaboration time.
  function automatic logic [255:0] addr_mask(input logic wr);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 256; i++)
      m[i] = (i < int'(REG_COUNT)) && (!wr || i >= int'(RO_LIMIT));
    return m;
  endfunction

  localparam logic [255:0] RD_MASK = addr_mask(1'b0);
  localparam logic [255:0] WR_MASK = addr_mask(1'b1);

  typedef enum logic [2:0] {IDLE, CMD, WADDR, RADDR, WDATA, RDATA, IGNORE} state_t;
  state_t state_q, state_d;

  logic [2:0] sclk_q, cs_q, mosi_q;
  logic       rise_q, fall_q, cs_fall_q, cs_rise_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shin_q;
  logic [7:0] shout_q;
  logic [7:0] ptr_q;
  logic       load_pend_q;
  logic       miso_q;
  logic       reg_wr_valid_q;
  logic [7:0] reg_wr_addr_q, reg_wr_data_q;
  logic [7:0] regs_q [REG_COUNT];

  logic [7:0] rx_byte, rd_val;
  logic       byte_done;

  assign rx_byte   = {shin_q, mosi_q[2]};
  assign byte_done = rise_q && (bit_cnt_q == 3'd7);

  // Synchronizers; [1] is the synchronized level, [2] its previous value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q    <= '0;
      cs_q      <= '1;
      mosi_q    <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      cs_fall_q <= 1'b0;
      cs_rise_q <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[1:0], spi.SPI_SCLK};
      cs_q      <= {cs_q[1:0], spi.SPI_CS};
      mosi_q    <= {mosi_q[1:0], spi.SPI_MOSI};
      rise_q    <= sclk_q[1] & ~sclk_q[2];
      fall_q    <= ~sclk_q[1] & sclk_q[2];
      cs_fall_q <= ~cs_q[1] & cs_q[2];
      cs_rise_q <= cs_q[1] & ~cs_q[2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (cs_fall_q) state_d = CMD;
        CMD:   if (byte_done) begin
                 if (rx_byte == CMD_WRITE)     state_d = WADDR;
                 else if (rx_byte == CMD_READ) state_d = RADDR;
                 else                          state_d = IGNORE;
               end
        WADDR: if (byte_done) state_d = WDATA;
        RADDR: if (byte_done) state_d = RDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = 8'h00;
    if (RD_MASK[ptr_q]) begin
      case (ptr_q)
        8'h08:   rd_val = sample_x;
        8'h09:   rd_val = sample_y;
        8'h0A:   rd_val = sample_z;
        default: rd_val = regs_q[ptr_q[AW-1:0]];
      endcase
    end
  end

  // A CS rise outranks any SCLK event in the same cycle, so a partial byte never commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q      <= '0;
      shin_q         <= '0;
      shout_q        <= '0;
      ptr_q          <= '0;
      load_pend_q    <= 1'b0;
      miso_q         <= 1'b0;
      reg_wr_valid_q <= 1'b0;
      reg_wr_addr_q  <= '0;
      reg_wr_data_q  <= '0;
      for (int i = 0; i < int'(REG_COUNT); i++) regs_q[i] <= '0;
      regs_q[0] <= DEVID_AD;
      regs_q[1] <= 8'h1D;
      regs_q[2] <= PARTID;
    end else begin
      reg_wr_valid_q <= 1'b0;
      if (cs_rise_q || state_q == IDLE) begin
        bit_cnt_q   <= '0;
        miso_q      <= 1'b0;
        load_pend_q <= 1'b0;
      end else begin
        if (rise_q) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          shin_q    <= rx_byte[6:0];
          if (bit_cnt_q == 3'd7) begin
            case (state_q)
              WADDR: ptr_q <= rx_byte;
              RADDR: begin
                ptr_q       <= rx_byte;
                load_pend_q <= 1'b1;
              end
              WDATA: begin
                if (WR_MASK[ptr_q]) begin
                  regs_q[ptr_q[AW-1:0]] <= rx_byte;
                  reg_wr_valid_q        <= 1'b1;
                  reg_wr_addr_q         <= ptr_q;
                  reg_wr_data_q         <= rx_byte;
                end
                ptr_q <= ptr_q + 8'd1;
              end
              RDATA: load_pend_q <= 1'b1;
              default: ;
            endcase
          end
        end
        if (fall_q && state_q == RDATA) begin
          if (load_pend_q) begin
            miso_q      <= rd_val[7];
            shout_q     <= {rd_val[6:0], 1'b0};
            ptr_q       <= ptr_q + 8'd1;
            load_pend_q <= 1'b0;
          end else begin
            miso_q  <= shout_q[7];
            shout_q <= {shout_q[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign spi.SPI_MISO = miso_q;
  assign reg_wr_valid = reg_wr_valid_q;
  assign reg_wr_addr  = reg_wr_addr_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign active       = ~cs_q[1];

endmodule

// File: tb/tb_spi_adxl362_responder.sv
// Bench for spi_adxl362_responder: directed protocol cases plus randomized
// transactions, scored against a register-level model of the device.
module tb_spi_adxl362_responder;
  logic clk = 1'b0;
  logic rst;
  logic sclk_r, mosi_r, cs_a, cs_b;
  logic cs_hi;
  logic [7:0] sample_x, sample_y, sample_z;
  logic wv_a, wv_b, act_a, act_b;
  logic [7:0] wa_a, wd_a, wa_b, wd_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise_cyc = 0;

  logic [7:0]  mreg [2][256];
  logic [7:0]  exp_miso [$];
  logic [15:0] exp_wr_a [$];
  logic [15:0] exp_wr_b [$];

  spi_adxl362_responder_if ifa ();
  spi_adxl362_responder_if ifb ();

  assign ifa.SPI_SCLK = sclk_r;
  assign ifa.SPI_MOSI = mosi_r;
  assign ifa.SPI_CS   = cs_a;
  assign ifb.SPI_SCLK = sclk_r;
  assign ifb.SPI_MOSI = mosi_r;
  assign ifb.SPI_CS   = cs_b;
  assign cs_hi = cs_a & cs_b;

  spi_adxl362_responder dut_a (
    .clk(clk), .rst(rst), .spi(ifa),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .reg_wr_valid(wv_a), .reg_wr_addr(wa_a), .reg_wr_data(wd_a), .active(act_a)
  );

  spi_adxl362_responder #(.REG_COUNT(256), .RO_LIMIT(8'h00)) dut_b (
    .clk(clk), .rst(rst), .spi(ifb),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .reg_wr_valid(wv_b), .reg_wr_addr(wa_b), .reg_wr_data(wd_b), .active(act_b)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] readval(input int dut, input logic [7:0] a);
    int rc;
    rc = (dut == 1) ? 256 : 64;
    if (int'(a) >= rc) return 8'h00;
    if (a == 8'h08) return sample_x;
    if (a == 8'h09) return sample_y;
    if (a == 8'h0A) return sample_z;
    return mreg[dut][a];
  endfunction

  task automatic init_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mreg[d][i] = 8'h00;
      mreg[d][0] = 8'hAD;
      mreg[d][1] = 8'h1D;
      mreg[d][2] = 8'hF2;
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, input int half);
    for (int i = 7; i > 7 - n; i--) begin
      mosi_r = b[i];
      repeat (half) @(negedge clk);
      sclk_r = 1'b1;
      last_rise_cyc = cyc;
      repeat (half) @(negedge clk);
      sclk_r = 1'b0;
    end
  endtask

  // pkt holds up to five bytes, first byte in bits [39:32]; abort_bits of the
  // following byte are clocked before CS is released.
  task automatic send(input int dut, input int nb, input logic [39:0] pkt,
                      input int abort_bits, input int half);
    logic [7:0] ptr, b, e, cmd;
    int ro, rc;
    ro  = (dut == 1) ? 0 : 'h20;
    rc  = (dut == 1) ? 256 : 64;
    cmd = pkt[39:32];
    ptr = 8'h00;
    for (int i = 0; i < nb; i++) begin
      b = pkt[39-8*i -: 8];
      e = 8'h00;
      if (i == 1) begin
        ptr = b;
      end else if (i >= 2 && cmd == 8'h0B) begin
        e = readval(dut, ptr);
        ptr = ptr + 8'd1;
      end else if (i >= 2 && cmd == 8'h0A) begin
        if (int'(ptr) >= ro && int'(ptr) < rc) begin
          mreg[dut][ptr] = b;
          if (dut == 1) exp_wr_b.push_back({ptr, b});
          else          exp_wr_a.push_back({ptr, b});
        end
        ptr = ptr + 8'd1;
      end
      exp_miso.push_back(e);
    end
    @(negedge clk);
    if (dut == 1) cs_b = 1'b0;
    else          cs_a = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nb; i++) spi_bits(pkt[39-8*i -: 8], 8, half);
    if (abort_bits > 0 && nb < 5) spi_bits(pkt[39-8*nb -: 8], abort_bits, half);
    repeat (half) @(negedge clk);
    check("active_during_cs", (dut == 1) ? act_b : act_a, 1);
    cs_a = 1'b1;
    cs_b = 1'b1;
    repeat (8) @(negedge clk);
    check("active_after_cs", {act_a, act_b}, 0);
    check("miso_after_cs", {ifa.SPI_MISO, ifb.SPI_MISO}, 0);
  endtask

  task automatic wr_chk(input int dut, input logic [7:0] a, input logic [7:0] d);
    logic [15:0] e;
    if ((dut == 1) ? (exp_wr_b.size() == 0) : (exp_wr_a.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL wr_unexpected dut%0d: got addr 0x%02h data 0x%02h, required no write", dut, a, d);
    end else begin
      e = (dut == 1) ? exp_wr_b.pop_front() : exp_wr_a.pop_front();
      check("wr_addr", a, e[15:8]);
      check("wr_data", d, e[7:0]);
      check("wr_latency", cyc - last_rise_cyc, 4);
    end
  endtask

  // Write monitor
  initial forever begin
    @(negedge clk);
    if (wv_a === 1'b1) wr_chk(0, wa_a, wd_a);
    if (wv_b === 1'b1) wr_chk(1, wa_b, wd_b);
  end

  // MISO monitor: assembles bytes at each SCLK rise, restarts on CS release
  initial begin
    int mbits;
    logic [7:0] mbyte;
    mbits = 0;
    mbyte = 8'h00;
    forever begin
      @(posedge sclk_r or posedge cs_hi);
      if (cs_hi) begin
        mbits = 0;
      end else begin
        mbyte = {mbyte[6:0], cs_a ? ifb.SPI_MISO : ifa.SPI_MISO};
        mbits++;
        if (mbits == 8) begin
          mbits = 0;
          if (exp_miso.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_unexpected: got byte 0x%02h, required none", mbyte);
          end else begin
            check("miso_byte", mbyte, exp_miso.pop_front());
          end
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [7:0] cmd, addr;
    logic [39:0] pkt;
    int r, nb, ab;
    rst = 1'b1;
    cs_a = 1'b1;
    cs_b = 1'b1;
    sclk_r = 1'b0;
    mosi_r = 1'b0;
    sample_x = 8'h00;
    sample_y = 8'h00;
    sample_z = 8'h00;
    init_model();
    repeat (3) @(negedge clk);
    check("rst_miso", {ifa.SPI_MISO, ifb.SPI_MISO}, 0);
    check("rst_wr_valid", {wv_a, wv_b}, 0);
    check("rst_wr_addr", {wa_a, wa_b}, 0);
    check("rst_wr_data", {wd_a, wd_b}, 0);
    check("rst_active", {act_a, act_b}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send(0, 3, 40'h0B_00_00_00_00, 0, 50);
    send(0, 3, 40'h0A_2D_02_00_00, 0, 8);
    send(0, 3, 40'h0B_2D_00_00_00, 0, 8);
    sample_x = 8'h12;
    sample_y = 8'h34;
    sample_z = 8'h56;
    send(0, 5, 40'h0B_08_00_00_00, 0, 8);
    send(0, 3, 40'h0A_00_55_00_00, 0, 8);
    send(0, 3, 40'h0B_00_00_00_00, 0, 8);
    send(0, 3, 40'h0B_50_00_00_00, 0, 8);
    send(0, 3, 40'h55_A5_3C_00_00, 0, 8);
    send(0, 2, 40'h0A_30_FF_00_00, 4, 8);
    send(0, 3, 40'h0B_30_00_00_00, 0, 8);
    send(1, 4, 40'h0A_FF_11_22_00, 0, 8);
    send(1, 4, 40'h0B_FF_00_00_00, 0, 8);

    for (int t = 0; t < 30; t++) begin
      sample_x = 8'($urandom);
      sample_y = 8'($urandom);
      sample_z = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r < 4)      cmd = 8'h0A;
      else if (r < 8) cmd = 8'h0B;
      else begin
        cmd = 8'($urandom);
        if (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'h00;
      end
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
      nb = $urandom_range(3, 5);
      ab = ($urandom_range(0, 5) == 0 && nb < 5) ? $urandom_range(1, 7) : 0;
      pkt = {cmd, addr, 8'($urandom), 8'($urandom), 8'($urandom)};
      send(0, nb, pkt, ab, $urandom_range(4, 10));
    end

    repeat (20) @(negedge clk);
    check("miso_queue_drained", exp_miso.size(), 0);
    check("wr_queue_a_drained", exp_wr_a.size(), 0);
    check("wr_queue_b_drained", exp_wr_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
